tft_fb_arb: RTL and testbench



---
 rtl/tft_fb_pkg.sv | 22 ++
 rtl/tft_pix_fifo.sv | 68 ++++++
 rtl/tft_fb_arb.sv | 145 ++++++++++++++
 tb/tb_tft_fb_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_fb_pkg.sv
// Shared constants and types for the TFT frame-buffer arbiter.
// Holds pixel width, default panel geometry, RGB565 colors and the grant encoding.
package tft_fb_pkg;

    localparam int PIX_W        = 16;
    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;

    localparam logic [PIX_W-1:0] COLOR_BLACK     = 16'h0000;
    localparam logic [PIX_W-1:0] COLOR_WHITE     = 16'hFFFF;
    localparam logic [PIX_W-1:0] COLOR_RED       = 16'hF800;
    localparam logic [PIX_W-1:0] COLOR_GREEN     = 16'h07E0;
    localparam logic [PIX_W-1:0] COLOR_BLUE      = 16'h001F;
    localparam logic [PIX_W-1:0] UNDERFLOW_COLOR = COLOR_RED;

    typedef enum logic [1:0] {
        GNT_IDLE    = 2'd0,
        GNT_DISP_RD = 2'd1,
        GNT_HOST_WR = 2'd2
    } gnt_e;

endpackage

// File: rtl/tft_pix_fifo.sv
// Show-ahead pixel FIFO: dout is the head entry whenever empty is low.
// Pop on empty and push on full are ignored; flush empties it in one cycle.
module tft_pix_fifo
    import tft_fb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [PIX_W-1:0] din,
    input  logic             pop,
    output logic [PIX_W-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only visible after being written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/tft_fb_arb.sv
// Frame-buffer arbiter: shares single-port frame memory between display prefetch
// and host writes, keeping a pixel FIFO ahead of tft_de.
module tft_fb_arb #(
    parameter int          H_ACTIVE        = tft_fb_pkg::H_ACTIVE_DEF,
    parameter int          V_ACTIVE        = tft_fb_pkg::V_ACTIVE_DEF,
    parameter int          ADDR_W          = 17,
    parameter int          FIFO_DEPTH      = 16,
    parameter int          LOW_WATER       = 8,
    parameter logic [15:0] UNDERFLOW_COLOR = tft_fb_pkg::UNDERFLOW_COLOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              de_in,
    output logic [15:0]       pix_out,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic              wr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              underflow,
    output logic              fetch_done
);
    import tft_fb_pkg::*;

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int LVL_W = CW + 1;
    localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

    logic              vs_d_q;
    logic              active_q, active_d;
    logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic              fetch_done_q, fetch_done_d;
    logic              underflow_q, underflow_d;

    logic              fs;
    logic              permit;
    logic [LVL_W-1:0]  lvl;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_full;
    logic [15:0]       fifo_dout;
    logic              ret_push;
    gnt_e              gnt;

    assign fs  = vs_in && !vs_d_q;
    assign lvl = {1'b0, fifo_count} + LVL_W'(inflight_q);

    // Fetching stays off after reset until a frame start re-arms it.
    assign permit = active_q && !fetch_done_q && !fifo_full
                    && (lvl < LVL_W'(FIFO_DEPTH));

    // A return landing on frame start belongs to the old frame and is dropped.
    assign ret_push = inflight_q && !fs;

    tft_pix_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fs),
        .push  (ret_push),
        .din   (mem_rdata),
        .pop   (de_in && !fs),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        gnt = GNT_IDLE;
        if (fs)                                       gnt = GNT_IDLE;
        else if (permit && lvl < LVL_W'(LOW_WATER))   gnt = GNT_DISP_RD;
        else if (wr_req)                              gnt = GNT_HOST_WR;
        else if (permit)                              gnt = GNT_DISP_RD;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        case (gnt)
            GNT_DISP_RD: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr_q[ADDR_W-1:0];
            end
            GNT_HOST_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        active_d     = active_q;
        rd_addr_d    = rd_addr_q;
        fetch_done_d = fetch_done_q;
        underflow_d  = underflow_q;
        inflight_d   = (gnt == GNT_DISP_RD);
        if (fs) begin
            active_d     = 1'b1;
            rd_addr_d    = '0;
            fetch_done_d = 1'b0;
            underflow_d  = 1'b0;
        end else begin
            if (gnt == GNT_DISP_RD) begin
                rd_addr_d = rd_addr_q + 1'b1;
                if (rd_addr_q + 1'b1 == TOTAL) fetch_done_d = 1'b1;
            end
            if (de_in && fifo_empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_d_q       <= 1'b0;
            active_q     <= 1'b0;
            rd_addr_q    <= '0;
            inflight_q   <= 1'b0;
            fetch_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            vs_d_q       <= vs_in;
            active_q     <= active_d;
            rd_addr_q    <= rd_addr_d;
            inflight_q   <= inflight_d;
            fetch_done_q <= fetch_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign pix_out    = fifo_empty ? UNDERFLOW_COLOR : fifo_dout;
    assign underflow  = underflow_q;
    assign fetch_done = fetch_done_q;

endmodule

// File: tb/tb_tft_fb_arb.sv
// Directed bench for tft_fb_arb with a 1-cycle-latency memory model (word = address
// unless written by the host) and a fill-level model built from observed grants.
module tb_tft_fb_arb;
    localparam int ADDR_W = 17;
    localparam int H_ACT  = 480;
    localparam int V_ACT  = 4;
    localparam int TOTAL  = H_ACT * V_ACT;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              vs_in = 1'b0, de_in = 1'b0;
    logic [15:0]       pix_out;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [15:0]       wr_data = '0;
    logic              wr_ack, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata = '0;
    logic              underflow, fetch_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tft_fb_arb #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .ADDR_W(ADDR_W),
                 .FIFO_DEPTH(16), .LOW_WATER(8), .UNDERFLOW_COLOR(16'hF800)) dut (
        .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .pix_out(pix_out),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .underflow(underflow), .fetch_done(fetch_done)
    );

    logic [15:0] mem   [4096];
    bit          wflag [4096];

    function automatic logic [15:0] mem_word(input int a);
        return wflag[a] ? mem[a] : 16'(a);
    endfunction

    always @(posedge clk) begin
        if (mem_req && mem_we) begin
            mem[mem_addr[11:0]]   <= mem_wdata;
            wflag[mem_addr[11:0]] <= 1'b1;
        end
        if (mem_req && !mem_we) mem_rdata <= mem_word(int'(mem_addr[11:0]));
    end

    // Fill-level and read-activity model driven from observed grants and de_in.
    int cnt_m, infl_m, rd_count, max_rd;
    logic vs_prev;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_m <= 0; infl_m <= 0; vs_prev <= 1'b0; rd_count <= 0; max_rd <= 0;
        end else begin
            vs_prev <= vs_in;
            if (vs_in && !vs_prev) begin
                cnt_m <= 0; infl_m <= 0; rd_count <= 0; max_rd <= 0;
            end else begin
                cnt_m  <= cnt_m + infl_m - ((de_in && cnt_m != 0) ? 1 : 0);
                infl_m <= (mem_req && !mem_we) ? 1 : 0;
                if (mem_req && !mem_we) begin
                    rd_count <= rd_count + 1;
                    if (int'(mem_addr) > max_rd) max_rd <= int'(mem_addr);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        #1;
        checks++; if (pix_out !== 16'hF800) begin errors++; $display("FAIL reset_pix got=%h exp=f800", pix_out); end
        checks++; if ({wr_ack, mem_req, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b exp=000", {wr_ack, mem_req, mem_we}); end
        checks++; if (mem_addr !== '0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem addr=%h wdata=%h exp=0", mem_addr, mem_wdata); end
        checks++; if ({underflow, fetch_done} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {underflow, fetch_done}); end
        tick(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL no_fetch_before_fs cyc=%0d mem_req=%b exp=0", i, mem_req); end
        end
    endtask

    task automatic test_frame_start();
        tick(); vs_in = 1'b1; de_in = 1'b0; #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fs_idle mem_req=%b exp=0", mem_req); end
        for (int k = 1; k <= 16; k++) begin
            tick(); #1;
            checks++;
            if (!(mem_req === 1'b1 && mem_we === 1'b0 && int'(mem_addr) == k - 1)) begin
                errors++; $display("FAIL fill_read T+%0d req=%b we=%b addr=%0d exp addr=%0d", k, mem_req, mem_we, mem_addr, k - 1);
            end
            if (k == 3) begin
                checks++; if (pix_out !== 16'h0000) begin errors++; $display("FAIL first_pix got=%h exp=0000", pix_out); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_idle cyc=%0d mem_req=%b exp=0", k, mem_req); end
        end
    endtask

    task automatic test_single_write();
        tick(); vs_in = 1'b0; wr_req = 1'b1; wr_addr = 17'd3500; wr_data = 16'h1234; #1;
        checks++;
        if (!(wr_ack === 1'b1 && mem_we === 1'b1 && mem_req === 1'b1 && int'(mem_addr) == 3500 && mem_wdata === 16'h1234)) begin
            errors++; $display("FAIL host_write ack=%b we=%b addr=%0d wdata=%h exp ack=1 we=1 addr=3500 wdata=1234", wr_ack, mem_we, mem_addr, mem_wdata);
        end
        tick(); wr_req = 1'b0; #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse ack=%b exp=0", wr_ack); end
        checks++; if (mem_word(3500) !== 16'h1234) begin errors++; $display("FAIL write_landed got=%h exp=1234", mem_word(3500)); end
    endtask

    task automatic test_line_burst();
        int bad = 0;
        for (int j = 0; j < H_ACT; j++) begin
            tick(); de_in = 1'b1; #1;
            checks++;
            if (pix_out !== 16'(j)) begin
                errors++; bad++;
                if (bad < 8) $display("FAIL burst_pix idx=%0d got=%h exp=%h", j, pix_out, 16'(j));
            end
        end
        tick(); de_in = 1'b0; #1;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL burst_underflow got=%b exp=0", underflow); end
        repeat (20) tick();
    endtask

    task automatic test_host_contention();
        int k = 0;
        for (int j = 0; j < 64; j++) begin
            tick(); de_in = 1'b1; wr_req = 1'b1;
            wr_addr = ADDR_W'(3000 + k); wr_data = 16'(16'hA000 + k); #1;
            checks++; if (pix_out !== 16'(480 + j)) begin errors++; $display("FAIL cont_pix idx=%0d got=%h exp=%h", j, pix_out, 16'(480 + j)); end
            checks++;
            if (wr_ack !== ((cnt_m + infl_m) >= 8)) begin
                errors++; $display("FAIL cont_grant cyc=%0d ack=%b lvl=%0d exp ack=%b", j, wr_ack, cnt_m + infl_m, (cnt_m + infl_m) >= 8);
            end else if (wr_ack) begin
                k++;
            end else begin
                checks++; if (!(mem_req === 1'b1 && mem_we === 1'b0)) begin errors++; $display("FAIL cont_read cyc=%0d req=%b we=%b exp read", j, mem_req, mem_we); end
            end
        end
        tick(); wr_req = 1'b0; de_in = 1'b0; #1;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL cont_underflow got=%b exp=0", underflow); end
        checks++; if (k < 1) begin errors++; $display("FAIL cont_acks got=%0d exp>=1", k); end
        for (int i = 0; i < k; i++) begin
            checks++;
            if (mem_word(3000 + i) !== 16'(16'hA000 + i)) begin errors++; $display("FAIL cont_mem idx=%0d got=%h exp=%h", i, mem_word(3000 + i), 16'(16'hA000 + i)); end
        end
    endtask

    task automatic test_underflow();
        tick(); vs_in = 1'b0; de_in = 1'b0; #1;
        tick(); vs_in = 1'b1; de_in = 1'b1; #1;
        tick(); #1;
        checks++; if (pix_out !== 16'hF800) begin errors++; $display("FAIL uf_pix_t1 got=%h exp=f800", pix_out); end
        tick(); #1;
        checks++; if (pix_out !== 16'hF800 || underflow !== 1'b1) begin errors++; $display("FAIL uf_t2 pix=%h uf=%b exp pix=f800 uf=1", pix_out, underflow); end
        tick(); #1;
        checks++; if (pix_out !== 16'h0000) begin errors++; $display("FAIL uf_pix_t3 got=%h exp=0000", pix_out); end
        tick(); #1;
        checks++; if (pix_out !== 16'h0001 || underflow !== 1'b1) begin errors++; $display("FAIL uf_t4 pix=%h uf=%b exp pix=0001 uf=1", pix_out, underflow); end
        tick(); de_in = 1'b0; vs_in = 1'b0; #1;
        tick(); vs_in = 1'b1; #1;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky_at_fs got=%b exp=1", underflow); end
        tick(); #1;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_fetch_done();
        int n = 0;
        tick(); vs_in = 1'b0; #1;
        tick(); vs_in = 1'b1; de_in = 1'b1; #1;
        while (fetch_done !== 1'b1 && n < 2500) begin tick(); #1; n++; end
        checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL fetch_done_timeout got=%b exp=1 after %0d cycles", fetch_done, n); end
        checks++; if (rd_count != TOTAL || max_rd != TOTAL - 1) begin errors++; $display("FAIL fetch_count reads=%0d max=%0d exp %0d/%0d", rd_count, max_rd, TOTAL, TOTAL - 1); end
        repeat (30) tick();
        #1;
        checks++; if (rd_count != TOTAL) begin errors++; $display("FAIL no_reads_after_done reads=%0d exp=%0d", rd_count, TOTAL); end
        checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL fetch_done_hold got=%b exp=1", fetch_done); end
        tick(); vs_in = 1'b0; de_in = 1'b0; #1;
        tick(); vs_in = 1'b1; #1;
        tick(); #1;
        checks++;
        if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === '0 && fetch_done === 1'b0)) begin
            errors++; $display("FAIL restart req=%b we=%b addr=%0d done=%b exp read addr 0 done 0", mem_req, mem_we, mem_addr, fetch_done);
        end
    endtask

    task automatic test_fs_collision();
        int n = 0;
        tick(); vs_in = 1'b0; #1;
        tick(); vs_in = 1'b1; #1;
        tick(); vs_in = 1'b0; #1;
        repeat (3) tick();
        tick(); #1;
        checks++; if (!(mem_req === 1'b1 && mem_we === 1'b0 && int'(mem_addr) == 4)) begin errors++; $display("FAIL coll_pre_read req=%b addr=%0d exp read addr 4", mem_req, mem_addr); end
        tick(); vs_in = 1'b1; wr_req = 1'b1; wr_addr = 17'd3600; wr_data = 16'h5555; #1;
        checks++; if (wr_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL coll_fs ack=%b req=%b exp 0 0", wr_ack, mem_req); end
        tick(); #1;
        checks++; if (pix_out !== 16'hF800) begin errors++; $display("FAIL coll_empty pix=%h exp=f800", pix_out); end
        checks++; if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === '0)) begin errors++; $display("FAIL coll_first_read req=%b we=%b addr=%0d exp read 0", mem_req, mem_we, mem_addr); end
        while (wr_ack !== 1'b1 && n < 40) begin tick(); #1; n++; end
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL coll_ack_timeout ack=%b exp=1", wr_ack); end
        tick(); wr_req = 1'b0; #1;
        checks++; if (mem_word(3600) !== 16'h5555 || pix_out !== 16'h0000) begin errors++; $display("FAIL coll_after mem=%h pix=%h exp 5555 0000", mem_word(3600), pix_out); end
    endtask

    task automatic test_midframe_reset();
        tick(); vs_in = 1'b0; de_in = 1'b1; #1;
        rst = 1'b0; #1;
        checks++; if (pix_out !== 16'hF800 || mem_req !== 1'b0) begin errors++; $display("FAIL mid_reset pix=%h req=%b exp f800 0", pix_out, mem_req); end
        tick(); rst = 1'b1; de_in = 1'b0;
        repeat (3) tick();
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_idle req=%b exp=0", mem_req); end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_single_write();
        test_line_burst();
        test_host_contention();
        test_underflow();
        test_fetch_done();
        test_fs_collision();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
